// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants, receiver state encoding and the keypad map.
package ps2_pkg;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    localparam logic [7:0] SC_KP0 = 8'h70;
    localparam logic [7:0] SC_KP1 = 8'h69;
    localparam logic [7:0] SC_KP2 = 8'h72;
    localparam logic [7:0] SC_KP3 = 8'h7A;
    localparam logic [7:0] SC_KP4 = 8'h6B;
    localparam logic [7:0] SC_KP5 = 8'h73;
    localparam logic [7:0] SC_KP6 = 8'h74;
    localparam logic [7:0] SC_KP7 = 8'h6C;
    localparam logic [7:0] SC_KP8 = 8'h75;
    localparam logic [7:0] SC_KP9 = 8'h7D;
    localparam logic [7:0] SC_E_LEFT  = 8'h6B;
    localparam logic [7:0] SC_E_RIGHT = 8'h74;

    typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_e;

    typedef struct packed {
        logic       hit;
        logic [3:0] digit;
    } key_map_t;

    // Extended codes only cover the arrow keys that share digit positions 4/6.
    function automatic key_map_t map_key(input logic ext, input logic [7:0] code);
        key_map_t r;
        r.hit   = 1'b1;
        r.digit = 4'd0;
        if (ext) begin
            case (code)
                SC_E_LEFT:  r.digit = 4'd4;
                SC_E_RIGHT: r.digit = 4'd6;
                default:    r.hit   = 1'b0;
            endcase
        end else begin
            case (code)
                SC_KP0:  r.digit = 4'd0;
                SC_KP1:  r.digit = 4'd1;
                SC_KP2:  r.digit = 4'd2;
                SC_KP3:  r.digit = 4'd3;
                SC_KP4:  r.digit = 4'd4;
                SC_KP5:  r.digit = 4'd5;
                SC_KP6:  r.digit = 4'd6;
                SC_KP7:  r.digit = 4'd7;
                SC_KP8:  r.digit = 4'd8;
                SC_KP9:  r.digit = 4'd9;
                default: r.hit   = 1'b0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 serial frame receiver: synchronizers, falling-edge detect, bit FSM,
// parity/stop check and inter-edge timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 25000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_stb,
    output logic       frame_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    // clk_sync[2] is the edge-detect history flop behind the 2-flop synchronizer.
    logic [2:0] clk_sync;
    logic [1:0] dat_sync;
    logic       fall;
    logic       bit_in;

    rx_state_e       state, state_d;
    logic [3:0]      bit_cnt, cnt_d;
    logic [7:0]      shreg, sr_d;
    logic            par_bit, par_d;
    logic [TO_W-1:0] to_cnt, to_d;
    logic            stb_d, err_d;

    assign fall    = clk_sync[2] & ~clk_sync[1];
    assign bit_in  = dat_sync[1];
    assign rx_byte = shreg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_sync  <= '1;
            dat_sync  <= '1;
            state     <= RX_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            to_cnt    <= '0;
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            dat_sync  <= {dat_sync[0], ps2_data};
            state     <= state_d;
            bit_cnt   <= cnt_d;
            shreg     <= sr_d;
            par_bit   <= par_d;
            to_cnt    <= to_d;
            byte_stb  <= stb_d;
            frame_err <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = bit_cnt;
        sr_d    = shreg;
        par_d   = par_bit;
        to_d    = to_cnt;
        stb_d   = 1'b0;
        err_d   = 1'b0;
        case (state)
            RX_IDLE: begin
                to_d  = '0;
                cnt_d = '0;
                if (fall && !bit_in) begin
                    state_d = RX_SHIFT;
                    cnt_d   = 4'd1;
                end
            end
            RX_SHIFT: begin
                if (fall) begin
                    to_d  = '0;
                    cnt_d = bit_cnt + 4'd1;
                    if (bit_cnt <= 4'd8) begin
                        sr_d = {bit_in, shreg[7:1]};
                    end else if (bit_cnt == 4'd9) begin
                        par_d = bit_in;
                    end else begin
                        state_d = RX_IDLE;
                        cnt_d   = '0;
                        if ((^shreg ^ par_bit) && bit_in) stb_d = 1'b1;
                        else                              err_d = 1'b1;
                    end
                end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    state_d = RX_IDLE;
                    cnt_d   = '0;
                    to_d    = '0;
                    err_d   = 1'b1;
                end else begin
                    to_d = to_cnt + TO_W'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/ps2_keypad_receiver.sv
// PS/2 keypad front end: scan-code decoder (E0/F0 prefixes) driving a held-key
// level and the last pressed digit.
module ps2_keypad_receiver
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 25000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       tx_start,
    output logic [3:0] Data,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       byte_stb;
    logic       ext, brk;
    key_map_t   key;

    ps2_frame_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (rx_byte),
        .byte_stb  (byte_stb),
        .frame_err (frame_err)
    );

    always_comb key = map_key(ext, rx_byte);

    // A break only releases tx_start when it names the digit currently shown,
    // so rolling from one key to another never produces a low cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ext      <= 1'b0;
            brk      <= 1'b0;
            tx_start <= 1'b0;
            Data     <= 4'd0;
        end else if (byte_stb) begin
            if (rx_byte == SC_EXT) begin
                ext <= 1'b1;
            end else if (rx_byte == SC_BRK) begin
                brk <= 1'b1;
            end else begin
                ext <= 1'b0;
                brk <= 1'b0;
                if (key.hit) begin
                    if (!brk) begin
                        Data     <= key.digit;
                        tx_start <= 1'b1;
                    end else if (tx_start && key.digit == Data) begin
                        tx_start <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keypad_receiver.sv
// Directed and randomized PS/2 frames checked against a scan-code level model.
module tb_ps2_keypad_receiver;

    localparam int TO   = 100;
    localparam int HALF = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       tx_start;
    logic [3:0] dut_data;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int err_exp = 0;
    bit watch_tx = 0;
    int tx_low_cnt = 0;

    // reference model state
    bit       m_ext, m_brk, m_tx;
    bit [3:0] m_data;

    byte unsigned keys0 [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
    byte unsigned pool  [19] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D,
                                 8'hE0, 8'hF0, 8'hF0, 8'hE0, 8'h1C, 8'h5A, 8'h12, 8'h6B, 8'h74};

    ps2_keypad_receiver #(.TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .tx_start  (tx_start),
        .Data      (dut_data),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_err) err_seen <= err_seen + 1;
        if (watch_tx && !tx_start) tx_low_cnt <= tx_low_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive the first nbits of a frame (start, 8 data LSB first, odd parity, stop).
    task automatic send_bits(input byte unsigned b, input bit bad_par, input int nbits);
        bit [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = b;
        f[9]   = ~(^b) ^ bad_par;
        f[10]  = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            tick(HALF);
            ps2_clk = 1'b0;
            tick(HALF);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_tx = 0; m_data = 0;
    endtask

    task automatic model_byte(input byte unsigned b);
        bit hit;
        bit [3:0] d;
        hit = 0; d = 0;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            if (m_ext) begin
                if (b == 8'h6B) begin hit = 1; d = 4; end
                if (b == 8'h74) begin hit = 1; d = 6; end
            end else begin
                for (int k = 0; k < 10; k++)
                    if (keys0[k] == b) begin hit = 1; d = 4'(k); end
            end
            if (hit) begin
                if (!m_brk) begin m_data = d; m_tx = 1; end
                else if (m_tx && m_data == d) m_tx = 0;
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic send_frame(input byte unsigned b, input bit bad, input string tag);
        send_bits(b, bad, 11);
        tick(2);
        if (bad) err_exp++;
        else model_byte(b);
        chk({tag, ".tx"}, int'(tx_start), int'(m_tx));
        chk({tag, ".data"}, int'(dut_data), int'(m_data));
        chk({tag, ".err"}, err_seen, err_exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        tick(3);
        rst_n = 1'b1;
        model_reset();
        tick(2);
    endtask

    initial begin
        byte unsigned b;
        bit bad;
        model_reset();
        do_reset();
        chk("rst.tx", int'(tx_start), 0);
        chk("rst.data", int'(dut_data), 0);
        chk("rst.err", int'(frame_err), 0);

        // KP6 make with exact latency from the stop-bit edge, then break
        send_bits(8'h74, 0, 10);
        ps2_data = 1'b1;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(3);
        chk("lat.early", int'(tx_start), 0);
        tick(1);
        chk("lat.tx", int'(tx_start), 1);
        chk("lat.data", int'(dut_data), 6);
        tick(HALF - 4);
        ps2_clk = 1'b1;
        model_byte(8'h74);
        send_frame(8'hF0, 0, "kp6.f0");
        send_frame(8'h74, 0, "kp6.brk");
        chk("kp6.tx0", int'(tx_start), 0);
        chk("kp6.d6", int'(dut_data), 6);

        // extended left arrow
        send_frame(8'hE0, 0, "ext.e0");
        send_frame(8'h6B, 0, "ext.mk");
        chk("ext.tx1", int'(tx_start), 1);
        chk("ext.d4", int'(dut_data), 4);
        send_frame(8'hE0, 0, "ext.e0b");
        send_frame(8'hF0, 0, "ext.f0");
        send_frame(8'h6B, 0, "ext.brk");
        chk("ext.tx0", int'(tx_start), 0);

        // parity error
        do_reset();
        send_frame(8'h69, 1, "par");
        chk("par.tx", int'(tx_start), 0);
        chk("par.d", int'(dut_data), 0);

        // timeout on a partial frame, then a good one
        do_reset();
        send_bits(8'h69, 0, 5);
        tick(TO + 10);
        err_exp++;
        chk("to.err", err_seen, err_exp);
        chk("to.tx", int'(tx_start), 0);
        send_frame(8'h69, 0, "to.kp1");
        chk("to.d1", int'(dut_data), 1);

        // rollover: tx_start must never drop while a key is held
        do_reset();
        send_frame(8'h74, 0, "roll.p6");
        watch_tx = 1;
        send_frame(8'h6B, 0, "roll.p4");
        chk("roll.d4", int'(dut_data), 4);
        send_frame(8'hF0, 0, "roll.f0");
        send_frame(8'h74, 0, "roll.b6");
        watch_tx = 0;
        tick(1);
        chk("roll.nolow", tx_low_cnt, 0);
        chk("roll.held", int'(tx_start), 1);
        send_frame(8'hF0, 0, "roll.f0b");
        send_frame(8'h6B, 0, "roll.b4");
        chk("roll.tx0", int'(tx_start), 0);

        // reset mid-frame
        do_reset();
        send_bits(8'h74, 0, 6);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        model_reset();
        tick(4);
        chk("mid.tx", int'(tx_start), 0);
        send_frame(8'h6B, 0, "mid.kp4");
        chk("mid.tx1", int'(tx_start), 1);
        chk("mid.d4", int'(dut_data), 4);

        // randomized scan-code stream
        do_reset();
        for (int n = 0; n < 60; n++) begin
            b   = pool[$urandom_range(0, 18)];
            bad = ($urandom_range(0, 7) == 0);
            send_frame(b, bad, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_keypad_receiver.md
PS2_KEYPAD_RECEIVER -- requirements
Module: ps2_keypad_receiver

Interface
REQ-001 Parameter TIMEOUT_CYC, default 25000, clk cycles without a PS/2 falling edge before a partial frame is discarded.
REQ-002 clk  input  1  system clock; one clock domain, all logic on posedge clk.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous.
REQ-005 ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous.
REQ-006 tx_start  output  1  level; high while a mapped key is held.
REQ-007 Data  output  4  code of the most recent mapped key pressed; digits 0-9.
REQ-008 frame_err  output  1  one-cycle pulse on a bad or timed-out frame.

Function
REQ-009 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge is synced ps2_clk 1 -> 0 between consecutive clk cycles.
REQ-010 Frame receiver states: IDLE, SHIFT; in IDLE a falling edge with data 0 (start bit) enters SHIFT with bit count 1; a falling edge with data 1 stays in IDLE.
REQ-011 In SHIFT, each falling edge samples data, LSB first: bits 1-8 data, bit 9 odd parity, bit 10 stop; after bit 10 return to IDLE.
REQ-012 A frame is valid iff parity over data+parity bit is odd and stop = 1; a valid frame yields an 8-bit byte strobe 1 cycle after the stop-bit edge.
REQ-013 An invalid frame SHALL produce no byte strobe and pulse frame_err for exactly 1 cycle.
REQ-014 In SHIFT, TIMEOUT_CYC consecutive cycles without a falling edge SHALL return to IDLE, pulse frame_err, and leave the decoder state unchanged.
REQ-015 Decoder flags ext and brk: byte 0xE0 sets ext; 0xF0 sets brk; any other byte is a key code, is consumed, and clears both flags.
REQ-016 Key map (ext=0): 0x70->0, 0x69->1, 0x72->2, 0x7A->3, 0x6B->4, 0x73->5, 0x74->6, 0x6C->7, 0x75->8, 0x7D->9; (ext=1): 0x6B->4 (left arrow), 0x74->6 (right arrow); all other codes unmapped.
REQ-017 Make of a mapped key: Data <= its code, tx_start <= 1, both registered in the cycle after the byte strobe; typematic repeats re-assert identical values.
REQ-018 Break of a mapped key whose code equals Data while tx_start = 1: tx_start <= 0, Data holds.
REQ-019 Break of a mapped key differing from Data, and any make or break of an unmapped key, SHALL leave tx_start and Data unchanged.
REQ-020 A new mapped make while another key is held SHALL overwrite Data; tx_start stays 1 with no low cycle.
REQ-021 Total latency: tx_start/Data update exactly 2 clk cycles after the synchronized stop-bit falling edge.

Reset
REQ-022 While rst_n = 0 at posedge clk: receiver to IDLE, bit count 0, timeout counter 0, ext = brk = 0, tx_start = 0, Data = 0, frame_err = 0, synchronizer flops = 1.
REQ-023 Reset asserted mid-frame SHALL discard the partial frame; the first byte accepted after release begins with a fresh start bit.

Structure
REQ-024 Shared package ps2_pkg holds scan-code constants (0xE0, 0xF0, the 12 mapped codes) and the receiver state enumeration.
REQ-025 Sub-module ps2_frame_rx contains synchronizers, edge detect, IDLE/SHIFT FSM, parity/stop check, and timeout, and outputs byte, byte strobe and frame_err; the top level contains only the decoder and output registers.

Verification
REQ-026 Frame 0x74 (KP6), then F0 74 -> tx_start = 1, Data = 6 two cycles after the first stop edge; tx_start = 0 after the second frame, Data stays 6.
REQ-027 E0 6B, then E0 F0 6B -> tx_start = 1, Data = 4, then tx_start = 0.
REQ-028 0x69 with parity bit flipped -> one frame_err pulse; tx_start = 0, Data = 0 unchanged.
REQ-029 Start bit plus 4 data bits, then silence of TIMEOUT_CYC+1 cycles, then valid 0x69 -> one frame_err pulse, then tx_start = 1, Data = 1.
REQ-030 Press 0x74, press 0x6B, break 0x74 -> Data = 6, then 4; tx_start stays 1 throughout; break F0 6B drops tx_start to 0.
REQ-031 rst_n low for 1 cycle after bit 5 of 0x74, then a full 0x6B frame -> no output from the aborted frame; tx_start = 1, Data = 4.
